// File: rtl/scoreboard_uart_tx_if.sv
// Scoreboard snapshot request, snapshot fields and UART status outputs,
// bundled so the transmitter and whatever feeds it share one port.
interface scoreboard_uart_tx_if;
    logic       send;
    logic       team_sw;
    logic [7:0] runs;
    logic [3:0] wickets;
    logic [7:0] ball_count;
    logic       inning_over;
    logic       game_over;
    logic       winner;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic       dropped;

    modport master (
        output send, team_sw, runs, wickets, ball_count,
               inning_over, game_over, winner,
        input  tx, busy, frame_done, dropped
    );

    modport slave (
        input  send, team_sw, runs, wickets, ball_count,
               inning_over, game_over, winner,
        output tx, busy, frame_done, dropped
    );
endinterface

// File: rtl/scoreboard_uart_tx.sv
// Scoreboard snapshot transmitter: captures a match snapshot on each send
// pulse and serialises it as a 5-byte 8N1 UART frame
// (0xA5, status, runs, ball_count, xor checksum). One snapshot can wait
// behind the active frame; a newer one replaces it and reports a drop.
module scoreboard_uart_tx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input logic                 clk,
    input logic                 rst,
    scoreboard_uart_tx_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] NEAR_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;
    localparam logic [2:0]       LAST_BYTE = 3'd4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       byte_idx;
    logic [7:0]       shift;
    logic [23:0]      cur_snap;
    logic [23:0]      pend_snap;
    logic             pend_vld;
    logic [23:0]      snap_in;
    logic             bit_end;
    logic             frame_end;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;
    logic             drop_q;

    // Byte idx of the frame built from a {status, runs, ball_count} snapshot.
    function automatic logic [7:0] frame_byte(input logic [23:0] snap,
                                              input logic [2:0]  idx);
        case (idx)
            3'd0:    frame_byte = SYNC_BYTE;
            3'd1:    frame_byte = snap[23:16];
            3'd2:    frame_byte = snap[15:8];
            3'd3:    frame_byte = snap[7:0];
            default: frame_byte = snap[23:16] ^ snap[15:8] ^ snap[7:0];
        endcase
    endfunction

    assign snap_in   = {bus.wickets, bus.team_sw, bus.inning_over, bus.game_over,
                        bus.winner, bus.runs, bus.ball_count};
    assign bit_end   = (baud_cnt == LAST_TICK);
    assign frame_end = (state == STOP) && (byte_idx == LAST_BYTE) && bit_end;

    // Transmit FSM, pending slot and all registered outputs. Data registers
    // are only loaded on capture, so reset leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            pend_vld <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= 1'b0;
            // A send mid-frame parks in the pending slot; the end-of-frame
            // edge is handled in STOP so the newest snapshot launches directly.
            if ((state != IDLE) && !frame_end && bus.send) begin
                pend_snap <= snap_in;
                pend_vld  <= 1'b1;
                drop_q    <= pend_vld;
            end
            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (bus.send) begin
                        cur_snap <= snap_in;
                        shift    <= SYNC_BYTE;
                        byte_idx <= '0;
                        baud_cnt <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_q     <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if ((byte_idx == LAST_BYTE) && (baud_cnt == NEAR_LAST)) begin
                        done_q <= 1'b1;
                    end
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_idx == LAST_BYTE) begin
                            if (bus.send || pend_vld) begin
                                cur_snap <= bus.send ? snap_in : pend_snap;
                                drop_q   <= bus.send && pend_vld;
                                pend_vld <= 1'b0;
                                byte_idx <= '0;
                                shift    <= SYNC_BYTE;
                                tx_q     <= 1'b0;
                                state    <= START;
                            end else begin
                                busy_q <= 1'b0;
                                state  <= IDLE;
                            end
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            shift    <= frame_byte(cur_snap, byte_idx + 3'd1);
                            tx_q     <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.dropped    = drop_q;
endmodule

// File: tb/tb_scoreboard_uart_tx.sv
// Bench for scoreboard_uart_tx at 16 clocks per bit: a cycle-level reference
// model queues expected frames and pulse times, a UART receiver monitor
// decodes tx and checks bytes, bit timing and pulses against those queues.
module tb_scoreboard_uart_tx;
    localparam int FRAME_CYC = 800;
    localparam int QD        = 512;

    logic clk = 1'b0;
    logic rst;
    scoreboard_uart_tx_if bus();

    scoreboard_uart_tx #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Counters: stimulus-side totals plus monitor-side totals folded in at the end.
    int check_cnt = 0, pass_cnt = 0;
    int mon_total = 0, mon_pass = 0;

    // Reference model state (posedge process only).
    int          cyc = 0;
    int          rst_evt = 0;
    bit          m_active = 0, m_pend = 0, exp_busy = 0;
    int          m_end = 0;
    logic [39:0] m_pend_frame, m_snap;
    logic [39:0] exp_mem [QD];
    int          fd_mem [QD];
    int          dr_mem [QD];
    int          exp_wr = 0, fd_wr = 0, dr_wr = 0;

    // Monitor state (negedge process only).
    int          exp_rd = 0, fd_rd = 0, dr_rd = 0, rx_rst_seen = 0;
    int          fd_seen = 0, dr_seen = 0, busy_err = 0, busy_first = 0;
    bit          rx_active = 0, have_exp = 0;
    int          rx_cnt = 0, rx_byte = 0, rx_glitch = 0;
    logic [9:0]  rx_bits;
    logic        ref_bit;
    logic [39:0] cur_exp;
    logic [7:0]  log_mem [1024];
    int          log_n = 0;

    function automatic logic [39:0] ref_frame(input logic [3:0] wk, input logic team,
                                              input logic io, input logic go, input logic win,
                                              input logic [7:0] r, input logic [7:0] b);
        int         status;
        logic [7:0] st;
        status = wk * 16 + team * 8 + io * 4 + go * 2 + win;
        st     = 8'(status);
        return {8'hA5, st, r, b, st ^ r ^ b};
    endfunction

    task automatic model_launch(input logic [39:0] f);
        m_active = 1;
        m_end    = cyc + FRAME_CYC;
        exp_mem[exp_wr % QD] = f;
        exp_wr++;
        fd_mem[fd_wr % QD] = cyc + FRAME_CYC - 1;
        fd_wr++;
    endtask

    task automatic model_drop();
        dr_mem[dr_wr % QD] = cyc;
        dr_wr++;
    endtask

    // Reference model: frames are 800 cycles, one waiting slot, newest wins.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_active = 0;
                m_pend   = 0;
                rst_evt++;
            end else begin
                m_snap = ref_frame(bus.wickets, bus.team_sw, bus.inning_over, bus.game_over,
                                   bus.winner, bus.runs, bus.ball_count);
                if (m_active && cyc == m_end) begin
                    if (bus.send) begin
                        if (m_pend) model_drop();
                        model_launch(m_snap);
                    end else if (m_pend) begin
                        model_launch(m_pend_frame);
                    end else begin
                        m_active = 0;
                    end
                    m_pend = 0;
                end else if (m_active) begin
                    if (bus.send) begin
                        if (m_pend) model_drop();
                        m_pend       = 1;
                        m_pend_frame = m_snap;
                    end
                end else if (bus.send) begin
                    model_launch(m_snap);
                end
            end
            exp_busy = m_active || m_pend;
        end
    end

    task automatic mon_check(input string name, input bit ok, input longint act, input longint exp);
        mon_total++;
        if (ok) mon_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: UART receiver plus pulse and busy scoreboards.
    initial begin
        logic [7:0] exp_byte;
        logic [7:0] data;
        bit         ok;
        forever begin
            @(negedge clk);
            if (rst_evt != rx_rst_seen) begin
                rx_rst_seen = rst_evt;
                rx_active   = 0;
                rx_byte     = 0;
                exp_rd      = exp_wr;
                fd_rd       = fd_wr;
                dr_rd       = dr_wr;
            end
            if (bus.busy !== exp_busy) begin
                if (busy_err == 0) busy_first = cyc;
                busy_err++;
            end
            if (bus.frame_done) begin
                fd_seen++;
                if (fd_rd == fd_wr) mon_check("frame_done_unexpected", 0, cyc, -1);
                else begin
                    mon_check("frame_done_time", fd_mem[fd_rd % QD] == cyc, cyc, fd_mem[fd_rd % QD]);
                    fd_rd++;
                end
            end else if (fd_rd != fd_wr && fd_mem[fd_rd % QD] < cyc) begin
                mon_check("frame_done_missing", 0, cyc, fd_mem[fd_rd % QD]);
                fd_rd++;
            end
            if (bus.dropped) begin
                dr_seen++;
                if (dr_rd == dr_wr) mon_check("dropped_unexpected", 0, cyc, -1);
                else begin
                    mon_check("dropped_time", dr_mem[dr_rd % QD] == cyc, cyc, dr_mem[dr_rd % QD]);
                    dr_rd++;
                end
            end else if (dr_rd != dr_wr && dr_mem[dr_rd % QD] < cyc) begin
                mon_check("dropped_missing", 0, cyc, dr_mem[dr_rd % QD]);
                dr_rd++;
            end
            if (!rx_active && bus.tx == 1'b0) begin
                rx_active = 1;
                rx_cnt    = 0;
                rx_glitch = 0;
            end
            if (rx_active) begin
                if (rx_cnt % 16 == 0) ref_bit = bus.tx;
                else if (bus.tx !== ref_bit) rx_glitch++;
                if (rx_cnt % 16 == 8) rx_bits[rx_cnt / 16] = bus.tx;
                if (rx_cnt == 159) begin
                    rx_active = 0;
                    if (rx_byte == 0) begin
                        have_exp = (exp_rd != exp_wr);
                        if (have_exp) begin
                            cur_exp = exp_mem[exp_rd % QD];
                            exp_rd++;
                        end
                    end
                    data     = rx_bits[8:1];
                    exp_byte = 8'(cur_exp >> (8 * (4 - rx_byte)));
                    ok = have_exp && data == exp_byte && rx_bits[0] == 1'b0 &&
                         rx_bits[9] == 1'b1 && rx_glitch == 0;
                    mon_total++;
                    if (ok) mon_pass++;
                    else $display("FAIL uart_byte%0d: got %02h start=%0b stop=%0b glitches=%0d, expected %02h (frame queued=%0b, cycle %0d)",
                                  rx_byte, data, rx_bits[0], rx_bits[9], rx_glitch, exp_byte, have_exp, cyc);
                    log_mem[log_n % 1024] = data;
                    log_n++;
                    rx_byte = (rx_byte == 4) ? 0 : rx_byte + 1;
                end else begin
                    rx_cnt++;
                end
            end
        end
    end

    task automatic stim_check(input string name, input longint act, input longint exp);
        check_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive_noise();
        bus.team_sw     = 1'($urandom);
        bus.runs        = 8'($urandom);
        bus.wickets     = 4'($urandom);
        bus.ball_count  = 8'($urandom);
        bus.inning_over = 1'($urandom);
        bus.game_over   = 1'($urandom);
        bus.winner      = 1'($urandom);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_noise();
        end
    endtask

    task automatic do_send(input logic [3:0] wk, input logic team, input logic io,
                           input logic go, input logic win, input logic [7:0] r,
                           input logic [7:0] b);
        bus.wickets = wk; bus.team_sw = team; bus.inning_over = io;
        bus.game_over = go; bus.winner = win; bus.runs = r; bus.ball_count = b;
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        drive_noise();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk);
            drive_noise();
            n++;
        end
        stim_check(name, 64'(bus.busy), 0);
    endtask

    function automatic logic [39:0] logged(input int base);
        return {log_mem[base % 1024], log_mem[(base + 1) % 1024], log_mem[(base + 2) % 1024],
                log_mem[(base + 3) % 1024], log_mem[(base + 4) % 1024]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, fd0, dr0, busy_len, gap;
        rst = 1'b1;
        bus.send = 1'b0;
        drive_noise();
        step(3);
        stim_check("reset_tx", 64'(bus.tx), 1);
        stim_check("reset_busy", 64'(bus.busy), 0);
        stim_check("reset_frame_done", 64'(bus.frame_done), 0);
        stim_check("reset_dropped", 64'(bus.dropped), 0);
        rst = 1'b0;

        // Long idle with noisy inputs and no send.
        base = log_n; fd0 = fd_seen; dr0 = dr_seen;
        step(2000);
        stim_check("idle_bytes", log_n - base, 0);
        stim_check("idle_frame_done", fd_seen - fd0, 0);
        stim_check("idle_dropped", dr_seen - dr0, 0);
        stim_check("idle_tx", 64'(bus.tx), 1);
        stim_check("idle_busy", 64'(bus.busy), 0);

        // Two directed snapshots with known byte values.
        base = log_n; fd0 = fd_seen;
        do_send(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd45, 8'd17);
        stim_check("first_cycle_tx", 64'(bus.tx), 0);
        stim_check("first_cycle_busy", 64'(bus.busy), 1);
        wait_idle(1000, "frame1_end");
        stim_check("frame1_bytes", logged(base), 40'hA5382D1104);
        stim_check("frame1_done_count", fd_seen - fd0, 1);
        step(3);
        base = log_n;
        do_send(4'd10, 1'b0, 1'b1, 1'b1, 1'b1, 8'd150, 8'd120);
        wait_idle(1000, "frame2_end");
        stim_check("frame2_bytes", logged(base), 40'hA5A7967849);
        step(3);

        // Three sends inside one frame: middle one is dropped.
        base = log_n; dr0 = dr_seen;
        do_send(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd30);
        busy_len = 1;
        for (int i = 1; i < 3000; i++) begin
            bus.send = (i == 100 || i == 200);
            bus.runs = (i == 100) ? 8'd2 : 8'd3;
            bus.wickets = 4'd2; bus.team_sw = 1'b0; bus.inning_over = 1'b0;
            bus.game_over = 1'b0; bus.winner = 1'b0; bus.ball_count = 8'd30;
            @(negedge clk);
            bus.send = 1'b0;
            if (!bus.busy) break;
            busy_len++;
        end
        stim_check("burst_busy_len", busy_len, 1600);
        stim_check("burst_drops", dr_seen - dr0, 1);
        stim_check("burst_byte_count", log_n - base, 10);
        stim_check("burst_runs_first", log_mem[(base + 2) % 1024], 1);
        stim_check("burst_runs_second", log_mem[(base + 7) % 1024], 3);
        step(3);

        // Reset 300 cycles into a frame.
        fd0 = fd_seen;
        do_send(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd45, 8'd17);
        step(299);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stim_check("abort_tx", 64'(bus.tx), 1);
        stim_check("abort_busy", 64'(bus.busy), 0);
        step(900);
        stim_check("abort_no_frame_done", fd_seen - fd0, 0);
        base = log_n;
        do_send(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd45, 8'd17);
        wait_idle(1000, "after_abort_end");
        stim_check("after_abort_bytes", logged(base), 40'hA5382D1104);

        // Reset and send together: reset wins.
        base = log_n; fd0 = fd_seen;
        bus.send = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        rst = 1'b0;
        stim_check("rst_send_busy", 64'(bus.busy), 0);
        stim_check("rst_send_tx", 64'(bus.tx), 1);
        step(900);
        stim_check("rst_send_no_bytes", log_n - base, 0);
        stim_check("rst_send_no_done", fd_seen - fd0, 0);

        // Random snapshots with random spacing, including bursts.
        for (int i = 0; i < 30; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(100, 900);
            step(gap);
            do_send(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    8'($urandom), 8'($urandom));
        end
        wait_idle(5000, "random_drain");
        step(5);

        stim_check("frames_drained", exp_wr - exp_rd, 0);
        stim_check("frame_done_drained", fd_wr - fd_rd, 0);
        stim_check("dropped_drained", dr_wr - dr_rd, 0);
        stim_check("receiver_idle", rx_active, 0);
        stim_check("busy_trace_errors", busy_err, 0);
        if (busy_err != 0) $display("first busy disagreement at cycle %0d", busy_first);

        pass_cnt  += mon_pass;
        check_cnt += mon_total;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/scoreboard_uart_tx.md
SCOREBOARD_UART_TX -- requirements
Module: scoreboard_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 868 at defaults).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 send  input  1  one-cycle request to transmit a scoreboard snapshot (one pulse per delivery).
REQ-007 team_sw  input  1  batting team select (0 = team 1, 1 = team 2).
REQ-008 runs  input  8  current team runs.
REQ-009 wickets  input  4  current team wickets.
REQ-010 ball_count  input  8  legal deliveries bowled.
REQ-011 inning_over, game_over, winner  input  1 each  match status flags.
REQ-012 tx  output  1  UART 8N1 serial line, idle high.
REQ-013 busy  output  1  high while a frame is in progress or a snapshot is pending.
REQ-014 frame_done  output  1  one-cycle pulse on completion of a frame.
REQ-015 dropped  output  1  one-cycle pulse when a pending snapshot is overwritten.

Function
REQ-016 Snapshot, captured on the cycle send is sampled high: status byte = {wickets[3:0], team_sw, inning_over, game_over, winner}, plus runs and ball_count.
REQ-017 Frame = 5 bytes in order: 0xA5, status, runs, ball_count, checksum = status XOR runs XOR ball_count.
REQ-018 Each byte: start bit (0), 8 data bits LSB first, stop bit (1); each bit held exactly CLKS_PER_BIT cycles; no idle gap between bytes of a frame.
REQ-019 FSM states IDLE, START, DATA, STOP; IDLE->START on an accepted snapshot; START->DATA after one bit time; DATA->STOP after 8th bit; STOP->START (byte index < 4) or STOP->IDLE (byte index = 4).
REQ-020 Latency: send sampled in IDLE at cycle N -> tx low and busy high from cycle N+1.
REQ-021 frame_done SHALL pulse during the last cycle of byte 4's stop bit.
REQ-022 Buffering: one-deep pending register; send while a frame is active and pending empty -> snapshot stored in pending, no effect on the active frame.
REQ-023 send while pending full -> pending replaced with newest snapshot, dropped pulses the next cycle.
REQ-024 Pending valid at frame_done -> its start bit begins on the cycle after frame_done; pending cleared.
REQ-025 send on the frame_done cycle -> treated as arriving while busy (REQ-022/023 apply); transmission follows the snapshots in arrival order.
REQ-026 busy low only when FSM is IDLE and pending is empty; falls the cycle after frame_done if nothing is pending.
REQ-027 Input changes after capture SHALL NOT alter an in-flight or pending frame.

Reset
REQ-028 On rst: tx=1, busy=0, frame_done=0, dropped=0, FSM=IDLE, pending cleared, baud/bit/byte counters=0.
REQ-029 rst asserted mid-frame SHALL abort immediately; tx high the next cycle; no frame_done.
REQ-030 rst and send in the same cycle: rst wins, snapshot discarded.

Verification (CLK_HZ=16, BAUD=1 -> 16 clk/bit, 800 clk/frame)
REQ-031 send with team_sw=1, runs=45, wickets=3, ball_count=17, flags 0 -> bytes A5 38 2D 11 04; frame_done at cycle N+800.
REQ-032 send with team_sw=0, runs=150, wickets=10, ball_count=120, inning_over=game_over=winner=1 -> bytes A5 A7 96 78 49.
REQ-033 Three sends during one frame (runs 1,2,3) -> one dropped pulse; frames for runs 1 then 3 sent back-to-back; busy continuous for 1600 cycles.
REQ-034 rst at cycle 300 of a frame -> tx=1 at cycle 301, busy=0, no frame_done; a later send produces a complete correct frame.
REQ-035 Idle check: no send for 2000 cycles after reset -> tx=1, busy=0, no pulses.
REQ-036 Bit timing: every tx edge spaced at a multiple of 16 cycles from the start-bit falling edge; stop bits sampled high at mid-bit.
